// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Avalon memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IBUS,
    DRD,
    DWR,
    RESP
  } arb_state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout.sv
// Stall counter for one bus transaction; expired means the next stall cycle
// is the TIMEOUT-th one, so the arbiter aborts on that edge.
module bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM master between the fetch and data requesters, one
// transaction at a time, with a registered one-cycle done pulse per requester.
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int MAX_STREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_rreq,
  input  logic        d_wreq,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        err,
  input  logic        err_clr,
  output arb_state_t  dbg_state
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  // Handshake: requesters hold a level request until they see their done
  // pulse; the bus command is held stable until a cycle with waitrequest low.

  arb_state_t    state, state_n;
  logic [SW-1:0] streak, streak_n;
  logic          grant_i, grant_rd, grant_wr, finish, abort;
  logic          fetch_turn, bus_state, tmo_expired;

  always_comb begin
    state_n    = state;
    grant_i    = 1'b0;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    bus_state  = 1'b0;
    // Fetch only overtakes pending data once data has had MAX_STREAK turns.
    fetch_turn = i_req && (!(d_rreq || d_wreq) || streak == SW'(MAX_STREAK));
    case (state)
      IDLE: begin
        if (fetch_turn) begin
          grant_i = 1'b1;
          state_n = IBUS;
        end else if (d_wreq) begin
          grant_wr = 1'b1;
          state_n  = DWR;
        end else if (d_rreq) begin
          grant_rd = 1'b1;
          state_n  = DRD;
        end
      end
      IBUS, DRD, DWR: begin
        bus_state = 1'b1;
        if (!avm_waitrequest) begin
          finish  = 1'b1;
          state_n = RESP;
        end else if (tmo_expired) begin
          abort   = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    streak_n = '0;
    if (i_req) begin
      streak_n = (streak == SW'(MAX_STREAK)) ? streak : streak + SW'(1);
    end
  end

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clr     (grant_i || grant_rd || grant_wr),
    .inc     (bus_state && avm_waitrequest),
    .expired (tmo_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak         <= '0;
      i_rdata        <= '0;
      i_done         <= 1'b0;
      d_rdata        <= '0;
      d_done         <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'hF;
      err            <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_i) begin
        avm_address    <= i_addr;
        avm_read       <= 1'b1;
        avm_byteenable <= 4'hF;
        streak         <= '0;
      end
      if (grant_rd) begin
        avm_address    <= d_addr;
        avm_read       <= 1'b1;
        avm_byteenable <= 4'hF;
        streak         <= streak_n;
      end
      if (grant_wr) begin
        avm_address    <= d_addr;
        avm_write      <= 1'b1;
        avm_writedata  <= d_wdata;
        avm_byteenable <= d_be;
        streak         <= streak_n;
      end
      if (finish || abort) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
        if (state == IBUS) begin
          i_done  <= 1'b1;
          i_rdata <= abort ? ABORT_DATA : avm_readdata;
        end else begin
          d_done <= 1'b1;
          if (abort) begin
            d_rdata <= ABORT_DATA;
          end else if (state == DRD) begin
            d_rdata <= avm_readdata;
          end
        end
      end
      if (abort) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: a per-cycle vector table for single
// transactions plus hand sequences for arbitration, timeout and reset.
module tb_avalon_mem_arbiter;
  import mem_arb_pkg::*;

  logic        CLK, RST;
  logic        i_req, d_rreq, d_wreq, err_clr, avm_waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, avm_readdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, avm_address, avm_writedata;
  logic        i_done, d_done, avm_read, avm_write, err;
  logic [3:0]  avm_byteenable;
  arb_state_t  dbg_state;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] WHO_I = 2'd1;
  localparam logic [1:0] WHO_D = 2'd2;
  logic [1:0] exp_q[$];

  avalon_mem_arbiter #(.TIMEOUT(8), .MAX_STREAK(4)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_rreq(d_rreq), .d_wreq(d_wreq), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_rdata(d_rdata), .d_done(d_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output logic [1:0] who);
    who = 2'd0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #1;
      if (i_done) begin
        who = WHO_I;
        break;
      end
      if (d_done) begin
        who = WHO_D;
        break;
      end
    end
  endtask

  typedef struct {
    logic        i_req, d_rreq, d_wreq, wait_r;
    logic [31:0] rdata;
    logic        exp_read, exp_write, exp_i_done, exp_d_done;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    logic        chk_d;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [1:0]  who, exp_who;
    int          cnt;
    logic        seen;
    logic [31:0] ir;

    ir = 32'h0050_0093;
    // fetch, zero wait states
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ir,  1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  4'hF, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, ir,  1'b0, 1'b0, 1'b1, 1'b0, 32'h100,  4'hF, ir,    32'h0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 4'hF, ir,  32'h0, 1'b1};
    // write with 3 wait states
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 4'h3, ir, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b0};
    // read and write together: write only
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 4'h3, ir, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 4'h3, ir, 32'h0, 1'b0};
    // data read, one wait state at grant then ready
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 4'hF, ir, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 4'hF, ir, 32'h1234_5678, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 4'hF, ir, 32'h1234_5678, 1'b1};

    RST = 1'b1;
    i_req = 1'b0; d_rreq = 1'b0; d_wreq = 1'b0; err_clr = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    i_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;

    repeat (3) @(posedge CLK);
    #1;
    check("reset read", 32'(avm_read), 32'd0);
    check("reset write", 32'(avm_write), 32'd0);
    check("reset be", 32'(avm_byteenable), 32'hF);
    check("reset addr", avm_address, 32'h0);
    check("reset err", 32'(err), 32'd0);
    check("reset done", {30'd0, i_done, d_done}, 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    RST = 1'b0;

    // single transactions, one table row per clock
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      i_req = vecs[i].i_req; d_rreq = vecs[i].d_rreq; d_wreq = vecs[i].d_wreq;
      avm_waitrequest = vecs[i].wait_r; avm_readdata = vecs[i].rdata;
      @(posedge CLK);
      #1;
      check($sformatf("row%0d read", i), 32'(avm_read), 32'(vecs[i].exp_read));
      check($sformatf("row%0d write", i), 32'(avm_write), 32'(vecs[i].exp_write));
      check($sformatf("row%0d i_done", i), 32'(i_done), 32'(vecs[i].exp_i_done));
      check($sformatf("row%0d d_done", i), 32'(d_done), 32'(vecs[i].exp_d_done));
      check($sformatf("row%0d addr", i), avm_address, vecs[i].exp_addr);
      check($sformatf("row%0d be", i), 32'(avm_byteenable), 32'(vecs[i].exp_be));
      check($sformatf("row%0d i_rdata", i), i_rdata, vecs[i].exp_i_rdata);
      if (vecs[i].chk_d) check($sformatf("row%0d d_rdata", i), d_rdata, vecs[i].exp_d_rdata);
      if (vecs[i].exp_write) check($sformatf("row%0d wdata", i), avm_writedata, 32'hCAFE_F00D);
    end

    // fetch starvation limit: four data grants, then fetch, then data again
    @(negedge CLK);
    i_req = 1'b1; d_rreq = 1'b1; avm_waitrequest = 1'b0; avm_readdata = 32'h0000_0013;
    exp_q = {WHO_D, WHO_D, WHO_D, WHO_D, WHO_I, WHO_D};
    while (exp_q.size() > 0) begin
      wait_done(who);
      exp_who = exp_q.pop_front();
      check("t3 grant order", 32'(who), 32'(exp_who));
      @(negedge CLK);
      if (who == WHO_I) i_req = 1'b0;
      else d_rreq = 1'b0;
      @(negedge CLK);
      if (who == WHO_D && exp_q.size() > 0) d_rreq = 1'b1;
    end
    i_req = 1'b0; d_rreq = 1'b0;

    // timeout abort after 8 stall cycles
    @(negedge CLK);
    d_rreq = 1'b1; avm_waitrequest = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      #1;
      if (d_done) begin
        seen = 1'b1;
        break;
      end
      if (avm_read) cnt++;
    end
    check("t4 stall cycles", 32'(cnt), 32'd8);
    check("t4 done", 32'(seen), 32'd1);
    check("t4 abort data", d_rdata, 32'hDEAD_BEEF);
    check("t4 read dropped", 32'(avm_read), 32'd0);
    check("t4 err set", 32'(err), 32'd1);
    @(negedge CLK);
    d_rreq = 1'b0; avm_waitrequest = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t4 err sticky", 32'(err), 32'd1);
    @(negedge CLK);
    err_clr = 1'b1;
    @(posedge CLK);
    #1;
    check("t4 err cleared", 32'(err), 32'd0);
    @(negedge CLK);
    err_clr = 1'b0;

    // reset during a read stall
    @(negedge CLK);
    d_rreq = 1'b1; avm_waitrequest = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("t6 read before rst", 32'(avm_read), 32'd1);
    check("t6 state before rst", 32'(dbg_state), 32'(DRD));
    #2;
    RST = 1'b1;
    #1;
    check("t6 read async drop", 32'(avm_read), 32'd0);
    check("t6 state async", 32'(dbg_state), 32'(IDLE));
    d_rreq = 1'b0; avm_waitrequest = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      if (d_done) seen = 1'b1;
    end
    check("t6 no done", 32'(seen), 32'd0);
    check("t6 idle after", 32'(dbg_state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
